// File: rtl/rr_arb_mux.sv
// Round-robin arbiter feeding a one-deep registered output stage.
// Define RR_ARB_MUX_LOCK_EN to add in_lock, which holds priority on the granted channel.
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
`ifdef RR_ARB_MUX_LOCK_EN
    input  logic                 in_lock,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_sel;
    logic [SELW-1:0]  r_ptr;

    logic             w_load;
    logic             w_any;
    logic [SELW-1:0]  w_gnt;
    logic [SELW-1:0]  w_gnt_inc;
    logic [SELW-1:0]  w_ptr_nxt;
    logic [WIDTH-1:0] w_data;
    int               w_idx;

    assign w_load = !r_out_valid | out_ready;

    // Search from r_ptr upward; NCH need not be a power of two, so wrap explicitly.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        w_idx = 0;
        for (int k = 0; k < NCH; k++) begin
            if (!w_any) begin
                w_idx = int'(r_ptr) + k;
                if (w_idx >= NCH) begin
                    w_idx = w_idx - NCH;
                end
                if (in_valid[w_idx]) begin
                    w_any = 1'b1;
                    w_gnt = SELW'(w_idx);
                end
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (SELW'(i) == w_gnt) begin
                w_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (w_any) begin
            in_ready[w_gnt] = w_load;
        end
    end

    assign w_gnt_inc = (w_gnt == SELW'(NCH - 1)) ? '0 : w_gnt + SELW'(1);

`ifdef RR_ARB_MUX_LOCK_EN
    assign w_ptr_nxt = in_lock ? w_gnt : w_gnt_inc;
`else
    assign w_ptr_nxt = w_gnt_inc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_data;
                r_out_sel   <= w_gnt;
                r_ptr       <= w_ptr_nxt;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed-vector bench for rr_arb_mux (NCH=4, WIDTH=32).
// Lock checks run only when RR_ARB_MUX_LOCK_EN is defined.
module tb_rr_arb_mux;

    localparam int WIDTH = 32;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_sel;
`ifdef RR_ARB_MUX_LOCK_EN
    logic                 in_lock;
`endif

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef RR_ARB_MUX_LOCK_EN
        .in_lock   (in_lock),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic        oready;
        logic        dbeef;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [1:0]  exp_sel;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic [3:0] v, input logic r,
                                input logic b, input logic [3:0] er,
                                input logic eov, input logic [1:0] es,
                                input logic [31:0] ed);
        vec_t t;
        t.valid    = v;
        t.oready   = r;
        t.dbeef    = b;
        t.exp_rdy  = er;
        t.exp_ov   = eov;
        t.exp_sel  = es;
        t.exp_data = ed;
        return t;
    endfunction

    function automatic logic [NCH*WIDTH-1:0] mkdata(input logic dbeef);
        logic [NCH*WIDTH-1:0] d;
        for (int i = 0; i < NCH; i++) begin
            d[i*WIDTH +: WIDTH] = 32'h100 + i;
        end
        if (dbeef) begin
            d[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
        end
        return d;
    endfunction

    initial begin
        // valid, out_ready, beef, exp in_ready, exp ov/sel/data after edge
        tbl[0]  = mk(4'b1111, 1, 0, 4'b0001, 1, 0, 32'h100);
        tbl[1]  = mk(4'b1111, 1, 0, 4'b0010, 1, 1, 32'h101);
        tbl[2]  = mk(4'b1111, 1, 0, 4'b0100, 1, 2, 32'h102);
        tbl[3]  = mk(4'b1111, 1, 0, 4'b1000, 1, 3, 32'h103);
        tbl[4]  = mk(4'b1111, 1, 0, 4'b0001, 1, 0, 32'h100);
        tbl[5]  = mk(4'b0000, 1, 0, 4'b0000, 0, 0, 32'h100);
        tbl[6]  = mk(4'b0100, 1, 1, 4'b0100, 1, 2, 32'hDEADBEEF);
        tbl[7]  = mk(4'b1111, 0, 0, 4'b0000, 1, 2, 32'hDEADBEEF);
        tbl[8]  = mk(4'b1111, 0, 0, 4'b0000, 1, 2, 32'hDEADBEEF);
        tbl[9]  = mk(4'b1111, 0, 0, 4'b0000, 1, 2, 32'hDEADBEEF);
        tbl[10] = mk(4'b1001, 1, 0, 4'b1000, 1, 3, 32'h103);
        tbl[11] = mk(4'b1001, 1, 0, 4'b0001, 1, 0, 32'h100);
        tbl[12] = mk(4'b0100, 0, 0, 4'b0000, 1, 0, 32'h100);
        tbl[13] = mk(4'b1000, 1, 0, 4'b1000, 1, 3, 32'h103);
        tbl[14] = mk(4'b0110, 1, 0, 4'b0010, 1, 1, 32'h101);
        tbl[15] = mk(4'b0110, 1, 0, 4'b0100, 1, 2, 32'h102);
        tbl[16] = mk(4'b0011, 1, 0, 4'b0001, 1, 0, 32'h100);
        tbl[17] = mk(4'b0000, 0, 0, 4'b0000, 1, 0, 32'h100);
        tbl[18] = mk(4'b0000, 1, 0, 4'b0000, 0, 0, 32'h100);

        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        in_data   = mkdata(1'b0);
`ifdef RR_ARB_MUX_LOCK_EN
        in_lock   = 1'b0;
`endif
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            in_valid  = tbl[i].valid;
            out_ready = tbl[i].oready;
            in_data   = mkdata(tbl[i].dbeef);
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready),
                  32'(tbl[i].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i), 32'(out_valid),
                  32'(tbl[i].exp_ov));
            if (tbl[i].exp_ov) begin
                check($sformatf("v%0d_out_sel", i), 32'(out_sel),
                      32'(tbl[i].exp_sel));
            end
            check($sformatf("v%0d_out_data", i), out_data, tbl[i].exp_data);
        end

        // Mid-stream reset drops the held word; next grant searches from 0.
        in_valid  = 4'b1110;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        check("pre_rst_out_sel", 32'(out_sel), 32'd1);
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        check("mid_rst_out_sel", 32'(out_sel), 32'd0);
        in_valid  = 4'b1100;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'b0100);
        @(posedge clk);
        #1;
        check("post_rst_out_valid", 32'(out_valid), 32'd1);
        check("post_rst_out_sel", 32'(out_sel), 32'd2);
        check("post_rst_out_data", out_data, 32'h102);

`ifdef RR_ARB_MUX_LOCK_EN
        // ptr is 3 here; lock keeps channel 1 on top until released.
        begin
            logic       lk[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
            logic [1:0] exs[4] = '{2'd1, 2'd1, 2'd1, 2'd2};
            in_valid = 4'b0110;
            for (int j = 0; j < 4; j++) begin
                in_lock = lk[j];
                #1;
                check($sformatf("lock%0d_in_ready", j), 32'(in_ready),
                      32'(4'b0001 << exs[j]));
                @(posedge clk);
                #1;
                check($sformatf("lock%0d_out_sel", j), 32'(out_sel),
                      32'(exs[j]));
            end
            in_lock = 1'b0;
        end
`endif

        in_valid = '0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
